// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with run-time terminal value, load, wrap/saturate, TC pulse and sticky overflow
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_n_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RST_VAL);
  logic [WIDTH-1:0] q_q, q_d, cnt, term;
  logic tc_q, tc_d, ovf_q, ovf_d, hit;
  // a count above a lowered max is a terminal step going up, but just snaps to max going down
  always_comb begin
    hit   = up_i ? (q_q >= max_i) : (q_q == '0);
    term  = (up_i == SATURATE) ? max_i : '0;
    cnt   = hit ? term : up_i ? q_q + 1'b1 : (q_q > max_i) ? max_i : q_q - 1'b1;
    q_d   = !clr_n_i ? RV : load_i ? ((d_i > max_i) ? max_i : d_i) : en_i ? cnt : q_q;
    tc_d  = clr_n_i & ~load_i & en_i & hit;
    ovf_d = clr_n_i & (ovf_q | tc_d);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= RV;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign q_o   = q_q;
  assign tc_o  = tc_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: vector table, corner sequences and random run against a rule-level model
module tb_updown_mod_counter;
  localparam int W = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr_n, load, en, up;
  logic [W-1:0] d, mx;
  logic [W-1:0] qw, qs;
  logic tcw, tcs, ovw, ovs;
  int checks = 0, errors = 0;
  int mq[2], mtc[2], movf[2];

  updown_mod_counter #(.WIDTH(W), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .clr_n_i(clr_n), .en_i(en), .up_i(up), .load_i(load),
    .d_i(d), .max_i(mx), .q_o(qw), .tc_o(tcw), .ovf_o(ovw));
  updown_mod_counter #(.WIDTH(W), .SATURATE(1'b1), .RST_VAL(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .clr_n_i(clr_n), .en_i(en), .up_i(up), .load_i(load),
    .d_i(d), .max_i(mx), .q_o(qs), .tc_o(tcs), .ovf_o(ovs));

  typedef struct {
    int rst, clr_n, load, en, up, d, mx, q, tc, ovf;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int r, int c, int l, int e, int u, int dd, int m, int q, int t, int o);
    vec_t v;
    v.rst = r; v.clr_n = c; v.load = l; v.en = e; v.up = u; v.d = dd; v.mx = m;
    v.q = q; v.tc = t; v.ovf = o;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // model: counts over 0..max with plain integers, k=0 wrap (reset 0), k=1 saturate (reset 3)
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int m = int'(mx);
      if (rst || !clr_n) begin
        mq[k] = (k == 1) ? 3 : 0; mtc[k] = 0; movf[k] = 0;
      end else if (load) begin
        mq[k] = (int'(d) > m) ? m : int'(d); mtc[k] = 0;
      end else if (en && up) begin
        if (mq[k] < m) begin mq[k]++; mtc[k] = 0; end
        else begin mq[k] = (k == 1) ? m : 0; mtc[k] = 1; movf[k] = 1; end
      end else if (en) begin
        if (mq[k] == 0) begin mq[k] = (k == 1) ? 0 : m; mtc[k] = 1; movf[k] = 1; end
        else begin mq[k] = (mq[k] > m) ? m : mq[k] - 1; mtc[k] = 0; end
      end else mtc[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("wrap.q", int'(qw), mq[0]);
    chk("wrap.tc", int'(tcw), mtc[0]);
    chk("wrap.ovf", int'(ovw), movf[0]);
    chk("sat.q", int'(qs), mq[1]);
    chk("sat.tc", int'(tcs), mtc[1]);
    chk("sat.ovf", int'(ovs), movf[1]);
  endtask

  task automatic drive(int r, int c, int l, int e, int u, int dd, int m);
    rst = 1'(r); clr_n = 1'(c); load = 1'(l); en = 1'(e); up = 1'(u); d = W'(dd); mx = W'(m);
  endtask

  initial begin
    drive(1, 1, 0, 0, 1, 0, 9);
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 9, 0, 0, 0));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 1, 0, 1, 1, 0, 9, i, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 9, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 9, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 9, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 200, 50, 50, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 3, 50, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 50, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 9, 9, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 9, 8, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 40, 50, 40, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 10, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 40, 50, 40, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 10, 10, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 7, 20, 7, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 20, 8, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1, 5, 20, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr_n, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].d, tbl[i].mx);
      tick();
      chk($sformatf("tbl%0d.q", i), int'(qw), tbl[i].q);
      chk($sformatf("tbl%0d.tc", i), int'(tcw), tbl[i].tc);
      chk($sformatf("tbl%0d.ovf", i), int'(ovw), tbl[i].ovf);
    end
    // saturate holds at 0 going down with TC every enabled cycle
    drive(0, 1, 1, 0, 0, 0, 9);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 0, 9);
      tick();
      chk("satdn.q", int'(qs), 0);
      chk("satdn.tc", int'(tcs), 1);
      chk("wrapdn.q", int'(qw), (i == 0) ? 9 : 9 - i);
    end
    // saturate holds at max going up
    drive(0, 1, 1, 0, 1, 9, 9);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 0, 9);
      tick();
      chk("satup.q", int'(qs), 9);
      chk("satup.tc", int'(tcs), 1);
      chk("satup.ovf", int'(ovs), 1);
    end
    // CLR mid-count at Q=7, then RST mid-count
    drive(0, 1, 1, 0, 1, 6, 20);
    tick();
    drive(0, 1, 0, 1, 1, 0, 20);
    tick();
    chk("pre_clr.q", int'(qw), 7);
    drive(0, 0, 0, 1, 1, 0, 20);
    tick();
    chk("clr.q", int'(qw), 0);
    chk("clr.ovf", int'(ovw), 0);
    chk("clr.sat.q", int'(qs), 3);
    drive(0, 1, 0, 1, 1, 0, 20);
    tick();
    drive(1, 1, 0, 1, 1, 0, 20);
    tick();
    chk("rst.q", int'(qw), 0);
    chk("rst.tc", int'(tcw), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr_n = ($urandom_range(0, 49) != 0);
      load = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      d = W'($urandom);
      if ($urandom_range(0, 19) == 0)
        case ($urandom_range(0, 3))
          0: mx = '0;
          1: mx = '1;
          2: mx = W'($urandom);
          default: mx = W'($urandom_range(1, 15));
        endcase
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
